// File: rtl/audio_pkg.sv
// Shared types and constants for the audio capture/playback blocks.
package audio_pkg;

    localparam int AUDIO_DATA_W   = 8;
    localparam int AUDIO_ADDR_W   = 8;
    localparam int AUDIO_MIDSCALE = 128;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECORD,
        DONE
    } rec_state_t;

endpackage

// File: rtl/audio_recorder_if.sv
// Sample-stream, control and read-port bundle for the audio recorder.
interface audio_recorder_if #(
    parameter int ADDR_W = audio_pkg::AUDIO_ADDR_W,
    parameter int DATA_W = audio_pkg::AUDIO_DATA_W
);

    logic              ena;
    logic [DATA_W-1:0] audio_in;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output ena, audio_in, start, stop, rd_addr,
        input  busy, done, length, rd_data
    );

    modport slave (
        input  ena, audio_in, start, stop, rd_addr,
        output busy, done, length, rd_data
    );

endinterface

// File: rtl/audio_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read-before-write read.
module audio_ram
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // NOTE: non-blocking updates make a same-edge read return the pre-write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/audio_recorder.sv
// Triggered audio capture: waits for a sample beyond THRESH from midscale, then fills the RAM.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int THRESH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    audio_recorder_if.slave bus
);

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   THRESH_V = THRESH[DATA_W:0];
    localparam logic [ADDR_W:0]   LAST     = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    rec_state_t        state_d, state_q;
    logic [ADDR_W:0]   length_d, length_q;
    logic [DATA_W:0]   mag;
    logic              trigger;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        if (bus.audio_in >= MID) begin
            mag = {1'b0, bus.audio_in - MID};
        end else begin
            mag = {1'b0, MID - bus.audio_in};
        end
        trigger = bus.ena && (mag >= THRESH_V);
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        wr_en    = 1'b0;
        wr_addr  = length_q[ADDR_W-1:0];
        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = ARMED;
                    length_d = '0;
                end
            end
            ARMED: begin
                if (trigger) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    length_d = LEN_ONE;
                    state_d  = bus.stop ? DONE : RECORD;
                end else if (bus.stop) begin
                    state_d = DONE;
                end
            end
            RECORD: begin
                if (bus.ena) begin
                    wr_en    = 1'b1;
                    length_d = length_q + LEN_ONE;
                end
                // The final slot closes the capture on the same edge it is written.
                if (bus.stop || (bus.ena && length_q == LAST)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            length_q <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
        end
    end

    audio_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.audio_in),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.busy   = (state_q == ARMED) || (state_q == RECORD);
    assign bus.done   = (state_q == DONE);
    assign bus.length = length_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: directed scenarios plus random traffic against a capture model.
module tb_audio_recorder;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    audio_recorder_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    audio_recorder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

    audio_recorder #(.ADDR_W(8), .DATA_W(8), .THRESH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    audio_recorder #(.ADDR_W(8), .DATA_W(8), .THRESH(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture model: phase 0 waiting for start, 1 waiting for trigger, 2 capturing, 3 finished.
    logic [7:0] m_mem [256];
    bit         m_valid [256];
    int         m_phase = 0;
    int         m_len = 0;
    logic [7:0] m_rd = 8'h00;
    bit         m_rd_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        int mag;
        int nphase;
        int nlen;
        if (!rst_n) begin
            m_phase    <= 0;
            m_len      <= 0;
            m_rd       <= 8'h00;
            m_rd_known <= 1'b1;
        end else begin
            m_rd       <= m_mem[bus.rd_addr];
            m_rd_known <= m_valid[bus.rd_addr];
            mag    = int'(bus.audio_in) - AUDIO_MIDSCALE;
            if (mag < 0) mag = -mag;
            nphase = m_phase;
            nlen   = m_len;
            if (m_phase == 0 || m_phase == 3) begin
                if (bus.start && !bus.stop) begin
                    nphase = 1;
                    nlen   = 0;
                end
            end else if (m_phase == 1) begin
                if (bus.ena && mag >= 16) begin
                    m_mem[0]   <= bus.audio_in;
                    m_valid[0] <= 1'b1;
                    nlen       = 1;
                    nphase     = bus.stop ? 3 : 2;
                end else if (bus.stop) begin
                    nphase = 3;
                end
            end else begin
                if (bus.ena) begin
                    m_mem[m_len]   <= bus.audio_in;
                    m_valid[m_len] <= 1'b1;
                    nlen           = m_len + 1;
                end
                if (bus.stop || nlen == 256) nphase = 3;
            end
            m_phase <= nphase;
            m_len   <= nlen;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(bus.busy), 32'(m_phase == 1 || m_phase == 2));
            check("done", 32'(bus.done), 32'(m_phase == 3));
            check("length", 32'(bus.length), 32'(m_len));
            if (m_rd_known) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
        end
    end

    task automatic cyc(input bit e, input logic [7:0] d, input bit s, input bit p,
                       input logic [7:0] ra);
        bus.ena      = e;
        bus.audio_in = d;
        bus.start    = s;
        bus.stop     = p;
        bus.rd_addr  = ra;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        bus.ena = 1'b0; bus.audio_in = 8'h00; bus.start = 1'b0; bus.stop = 1'b0; bus.rd_addr = 8'h00;
        bus0.ena = 1'b0; bus0.audio_in = 8'h00; bus0.start = 1'b0; bus0.stop = 1'b0; bus0.rd_addr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_length", 32'(bus.length), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);

        // Trigger on 0x95 after ten midscale samples.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
        check("pre_trig_length", 32'(bus.length), 32'd0);
        cyc(1'b1, 8'h95, 1'b0, 1'b0, 8'h00);
        check("trig_length", 32'(bus.length), 32'd1);
        check("trig_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'h00);
        check("trig_addr0", 32'(bus.rd_data), 32'h95);

        // Stop together with a strobe: sample kept and counted.
        cyc(1'b1, 8'h42, 1'b0, 1'b1, 8'h05);
        check("stop_length", 32'(bus.length), 32'd6);
        check("stop_done", 32'(bus.done), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h05);
        check("stop_addr5", 32'(bus.rd_data), 32'h42);

        // Ramp fills the whole buffer.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
        check("ramp_busy_255", 32'(bus.busy), 32'd1);
        check("ramp_length_255", 32'(bus.length), 32'd255);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        check("full_length", 32'(bus.length), 32'd256);
        check("full_done", 32'(bus.done), 32'd1);
        check("full_busy", 32'(bus.busy), 32'd0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
        check("full_hold_length", 32'(bus.length), 32'd256);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'(i));
            check("ramp_read", 32'(bus.rd_data), 32'(i));
        end

        // Asynchronous reset in the middle of a capture.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        check("async_length", 32'(bus.length), 32'd0);
        check("async_rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start and stop together from IDLE: nothing happens.
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        check("startstop_busy", 32'(bus.busy), 32'd0);
        check("startstop_done", 32'(bus.done), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rearm_addr0", 32'(bus.rd_data), 32'hF0);
        check("rearm_length", 32'(bus.length), 32'd2);

        // Zero threshold: first strobe at midscale triggers.
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.ena = 1'b1; bus0.audio_in = 8'h80;
        @(negedge clk);
        bus0.ena = 1'b0;
        check("t0_length", 32'(bus0.length), 32'd1);
        check("t0_busy", 32'(bus0.busy), 32'd1);
        @(negedge clk);
        check("t0_addr0", 32'(bus0.rd_data), 32'h80);

        // Random traffic, compared every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0),
                8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
